// File: rtl/pll_lock_monitor_pkg.sv
// PLL lock monitor shared types: FSM state encoding and parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_mon_pkg;

  localparam int unsigned SETTLE_CYCLES_DEF = 1024;
  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned LOSS_W_DEF        = 8;
  localparam int unsigned BLINK_BIT_DEF     = 22;

  // Lock supervision states; WAIT is the reset state.
  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_LOST   = 2'd3
  } pll_state_e;

endpackage

// File: rtl/pll_lock_monitor_if.sv
// PLL-facing and status signals of the lock monitor, grouped as one bundle.
// Latency: n/a (wires only).
// Backpressure: none; the lock flags are level signals, the outputs are levels.
interface pll_lock_monitor_if
  import pll_mon_pkg::*;
#(
  parameter int unsigned LOSS_W = LOSS_W_DEF
);

  logic              pll_lock_i;       // USR_PLL_LOCKED, async to clk_i
  logic              pll_lock_stdy_i;  // USR_PLL_LOCKED_STDY, async to clk_i
  logic              stdy_clr_o;       // clear pulse to the steady-lock flag
  logic              sys_rst_n_o;      // reset for PLL-domain logic
  logic [LOSS_W-1:0] loss_cnt_o;       // saturating lock-loss count
  logic              led_o;            // status LED

  // PLL / board side: drives the lock flags, observes the monitor.
  modport master (
    output pll_lock_i, pll_lock_stdy_i,
    input  stdy_clr_o, sys_rst_n_o, loss_cnt_o, led_o
  );

  // Monitor side.
  modport slave (
    input  pll_lock_i, pll_lock_stdy_i,
    output stdy_clr_o, sys_rst_n_o, loss_cnt_o, led_o
  );

endinterface

// File: rtl/pll_lock_monitor_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous level input.
// Latency: STAGES clk_i edges from input change to q_o change.
// Backpressure: none.
module pll_lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Chain of flops, cleared by the synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock supervisor: releases PLL-domain reset after sustained lock, clears the steady flag and counts losses; loss counter present only with PLL_LOCK_LOSS_CNT_EN defined.
// Latency: SYNC_STAGES+1 edges lock->SETTLE, then SETTLE_CYCLES edges to sys_rst_n_o high; loss seen in SYNC_STAGES+1 edges.
// Backpressure: none; all inputs are levels sampled every clk_i edge.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned BLINK_BIT     = BLINK_BIT_DEF,
  parameter int unsigned LOSS_W        = LOSS_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pll_lock_monitor_if.slave pll_if
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic lock_s;
  logic stdy_s;

  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_if.pll_lock_i),
    .q_o   (lock_s)
  );

  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync_stdy (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_if.pll_lock_stdy_i),
    .q_o   (stdy_s)
  );

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [BLINK_BIT:0] hb_q, hb_d;
  logic               rst_n_q, rst_n_d;
  logic               clr_q, clr_d;

  // Next state, settle counter, heartbeat and registered reset/clear levels.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_WAIT: begin
        if (lock_s) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s || !stdy_s) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
    // Outputs are registered from the next state so they change on the
    // same edge that enters/leaves RUN and LOST.
    rst_n_d = (state_d == ST_RUN);
    clr_d   = (state_d == ST_LOST);
    // Heartbeat starts from 0 on RUN entry and is cleared on leaving RUN.
    hb_d    = (state_q == ST_RUN && state_d == ST_RUN) ? hb_q + 1'b1 : '0;
  end

  // State and output registers; reset holds the steady-lock flag cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_WAIT;
      settle_q <= '0;
      hb_q     <= '0;
      rst_n_q  <= 1'b0;
      clr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      hb_q     <= hb_d;
      rst_n_q  <= rst_n_d;
      clr_q    <= clr_d;
    end
  end

  assign pll_if.sys_rst_n_o = rst_n_q;
  assign pll_if.stdy_clr_o  = clr_q;
  assign pll_if.led_o       = (state_q == ST_RUN) && hb_q[BLINK_BIT];

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_q, loss_d;

  // Count each RUN->LOST transition, sticking at all-ones.
  always_comb begin
    loss_d = loss_q;
    if (state_q == ST_RUN && state_d == ST_LOST && loss_q != '1) begin
      loss_d = loss_q + 1'b1;
    end
  end

  // Loss counter register; a reset is not a loss and clears the count.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign pll_if.loss_cnt_o = loss_q;
`else
  assign pll_if.loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: stimulus pushes per-edge expectations, a negedge monitor compares.
// Latency: one expectation per clk_i edge, checked at the following negedge.
// Backpressure: none.
module tb_pll_lock_monitor;

  logic clk;
  logic rst_n;

  pll_lock_monitor_if #(.LOSS_W(2)) pif ();

  pll_lock_monitor #(
    .SETTLE_CYCLES (16),
    .SYNC_STAGES   (2),
    .BLINK_BIT     (3),
    .LOSS_W        (2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .pll_if (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       clr;
    logic [1:0] loss;
    logic       led;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   nloss  = 0;
  int   run_k  = 0;

  function automatic logic [1:0] exp_loss(input int n);
    logic [1:0] r;
    r = (n > 3) ? 2'd3 : 2'(n);
`ifndef PLL_LOCK_LOSS_CNT_EN
    r = 2'd0;
`endif
    return r;
  endfunction

  // Monitor: every negedge, compare outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (pif.sys_rst_n_o !== e.rstn || pif.stdy_clr_o !== e.clr ||
          pif.loss_cnt_o !== e.loss || pif.led_o !== e.led) begin
        n_miss++;
        $display("FAIL %s @%0t: got rstn=%b clr=%b loss=%0d led=%b, want rstn=%b clr=%b loss=%0d led=%b",
                 e.tag, $time, pif.sys_rst_n_o, pif.stdy_clr_o, pif.loss_cnt_o, pif.led_o,
                 e.rstn, e.clr, e.loss, e.led);
      end
    end
  end

  // One clk_i edge: drive inputs, queue the outputs expected after that edge.
  task automatic step(input logic r, input logic lk, input logic st,
                      input logic e_rstn, input logic e_clr, input int e_nl,
                      input logic e_led, input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n               = r;
    pif.pll_lock_i      = lk;
    pif.pll_lock_stdy_i = st;
    e.rstn = e_rstn;
    e.clr  = e_clr;
    e.loss = exp_loss(e_nl);
    e.led  = e_led;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Lock (re)applied from WAIT with flops clear: RUN on the 19th edge.
  task automatic settle_from_lock(input string tag);
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, nloss, 1'b0, tag);
    end
    run_k = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, nloss, 1'b0, {tag, "_rise"});
  endtask

  // Steady RUN cycles; LED follows heartbeat bit 3.
  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) begin
      run_k++;
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, nloss, run_k[3], "run_led");
    end
  endtask

  // Drop the steady flag only: LOST one cycle, then re-settle to RUN.
  task automatic loss_and_recover(input string tag);
    run_k++;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, nloss, run_k[3], {tag, "_sync1"});
    run_k++;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, nloss, run_k[3], {tag, "_sync2"});
    nloss++;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, nloss, 1'b0, {tag, "_lost"});
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, nloss, 1'b0, {tag, "_wait"});
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, nloss, 1'b0, {tag, "_settle"});
    end
    run_k = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, nloss, 1'b0, {tag, "_rerun"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d want 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    pif.pll_lock_i      = 1'b0;
    pif.pll_lock_stdy_i = 1'b0;

    // Reset state: clear flag held, everything else low.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, "reset");
    end

    // First lock: reset released 19 edges after lock high.
    settle_from_lock("first_lock");

    // Heartbeat: LED high for run_k 8..15, low 16..23, high again from 24.
    run_steps(24);

    // Five steady-flag losses: count 1,2,3,3,3 (0 without the counter).
    loss_and_recover("loss1");
    run_steps(2);
    loss_and_recover("loss2");
    run_steps(2);
    loss_and_recover("loss3");
    run_steps(2);
    loss_and_recover("loss4");
    run_steps(2);
    loss_and_recover("loss5");
    run_steps(9);

    // One-cycle reset in RUN: no LOST, count cleared, back to WAIT.
    nloss = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, "rst_in_run");

    // Re-settle to count 10, then a 3-cycle lock glitch.
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "settle_to_10");
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "glitch");
    end
    settle_from_lock("glitch_relock");
    run_steps(10);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1024, meaning cycles of continuous lock required before system reset is released (min 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth on the asynchronous lock inputs (min 2).
REQ-003 SHALL have parameter BLINK_BIT, default 22, meaning heartbeat counter bit driven to led_o in RUN.
REQ-004 SHALL have parameter LOSS_W, default 8, meaning width of the lock-loss counter.
REQ-005 clk_i  input  1  free-running reference clock (not the PLL output); sole clock.
REQ-006 rst_i  input  1  synchronous, active-low reset.
REQ-007 pll_lock_i  input  1  PLL USR_PLL_LOCKED, asynchronous to clk_i.
REQ-008 pll_lock_stdy_i  input  1  PLL USR_PLL_LOCKED_STDY, asynchronous to clk_i.
REQ-009 stdy_clr_o  output  1  active-high clear to the PLL steady-lock flag (inverted externally to USR_LOCKED_STDY_RST as required).
REQ-010 sys_rst_n_o  output  1  active-low reset for logic in the PLL clock domain.
REQ-011 loss_cnt_o  output  LOSS_W  saturating count of lock losses since reset.
REQ-012 led_o  output  1  status LED.

Function
REQ-013 Both lock inputs SHALL pass through SYNC_STAGES flops (reset value 0) giving lock_s and stdy_s; no other logic may use the raw inputs.
REQ-014 FSM SHALL have states WAIT, SETTLE, RUN, LOST; reset state WAIT.
REQ-015 WAIT: lock_s=1 -> SETTLE with settle counter cleared to 0; else stay.
REQ-016 SETTLE: lock_s=0 -> WAIT; else if counter==SETTLE_CYCLES-1 -> RUN; else counter increments.
REQ-017 RUN: lock_s=0 or stdy_s=0 -> LOST; else stay.
REQ-018 LOST SHALL last exactly one cycle, then go to WAIT unconditionally.
REQ-019 sys_rst_n_o SHALL be registered, 1 exactly in cycles where state==RUN (rises on the same edge RUN is entered, falls on the edge LOST is entered).
REQ-020 stdy_clr_o SHALL be registered, 1 for exactly the one cycle of LOST, 0 otherwise outside reset.
REQ-021 Heartbeat counter (BLINK_BIT+1 bits) SHALL count while in RUN, wrap freely, and hold 0 in every other state; led_o = heartbeat[BLINK_BIT] in RUN, 0 otherwise.
REQ-022 On entry to LOST, loss_cnt_o SHALL increment by 1, saturating at 2^LOSS_W-1 (no wrap).
REQ-023 Lock-input glitch shorter than SETTLE_CYCLES during SETTLE SHALL restart settling from WAIT, with no loss count and no stdy_clr_o pulse.
REQ-024 With SYNC_STAGES=2, SETTLE_CYCLES=N, lock_i rising before edge 0 SHALL give SETTLE after edge 3 and sys_rst_n_o=1 after edge 3+N.

Reset
REQ-025 While rst_i=0 at a clk_i edge: state WAIT, sync flops 0, settle/heartbeat counters 0, sys_rst_n_o=0, led_o=0, loss_cnt_o=0, stdy_clr_o=1.
REQ-026 Reset asserted in any state, including mid-SETTLE or RUN, SHALL take effect on the next edge without passing through LOST and without counting a loss.

Configuration
REQ-027 Macro PLL_LOCK_LOSS_CNT_EN defined: loss counter per REQ-022 present.
REQ-028 Macro undefined: counter logic removed, loss_cnt_o SHALL be constant 0, port list unchanged; all other behaviour identical.

Structure
REQ-029 Package pll_mon_pkg SHALL hold the FSM state enum (2-bit) and default values of SETTLE_CYCLES, SYNC_STAGES, LOSS_W.
REQ-030 One sub-module pll_lock_sync (parameterised SYNC_STAGES-deep single-bit synchroniser, sync active-low reset) SHALL be instantiated twice.

Verification
REQ-031 SETTLE_CYCLES=16: rst_i low 4 cycles, then pll_lock_i=pll_lock_stdy_i=1 -> sys_rst_n_o rises exactly 19 edges after lock high; stdy_clr_o 0 after reset.
REQ-032 In SETTLE at count 10, drop pll_lock_i 3 cycles -> state WAIT, sys_rst_n_o stays 0, loss_cnt_o stays 0; full 19-edge sequence restarts on re-lock.
REQ-033 In RUN, drop pll_lock_stdy_i only -> LOST one cycle, stdy_clr_o one-cycle pulse, sys_rst_n_o 0, loss_cnt_o 0->1, led_o 0.
REQ-034 LOSS_W=2, five RUN->LOST events -> loss_cnt_o 1,2,3,3,3; with PLL_LOCK_LOSS_CNT_EN undefined, always 0.
REQ-035 BLINK_BIT=3 in RUN -> led_o toggles every 8 cycles, first rise 8 cycles after RUN entry; returns 0 on LOST.
REQ-036 rst_i low for one cycle while in RUN -> next edge sys_rst_n_o=0, stdy_clr_o=1, loss_cnt_o=0, state WAIT.
